// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Program loader for the instruction RAM. Consumes a framed byte stream
// (length byte N, then N 32-bit words sent MSB-first, then an optional
// checksum byte) and issues one single-cycle write per assembled word to
// consecutive RAM addresses starting at BASE_ADDR.
//
// Optional feature macro: INST_LOADER_CHECKSUM_EN
//   defined   : a running XOR of all data bytes is kept and one extra
//               checksum byte is expected after the last word; a mismatch
//               ends the frame in the error state without a done pulse.
//   undefined : the frame ends right after the last word.
//
// Parameters
//   ADDR_W     instruction RAM address width (capacity 2^ADDR_W words)
//   BASE_ADDR  RAM address of the first loaded word
//
// Ports
//   clk       system clock, rising edge
//   clr       synchronous active-high reset
//   start     one-cycle pulse, begins a frame when idle or in error
//   byte_in   stream byte
//   byte_vld  byte_in valid this cycle
//   byte_rdy  loader accepts a byte this cycle (registered)
//   we        RAM write enable, one pulse per word
//   waddr     RAM write address
//   wdata     RAM write data, bits [32:25] hold the first byte of the word
//   busy      frame in progress
//   done      one-cycle pulse on successful frame end
//   err       sticky frame error, cleared by the next start
//   word_cnt  words written in the current/last frame
// ---------------------------------------------------------------------------
module inst_loader #(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_vld,
   output logic              byte_rdy,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [32:1]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_cnt
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam int                MAX_WORDS = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_FIN,
      S_ERR
   } state_t;

   state_t          state;
   logic [7:0]      len;
   logic [1:0]      byte_idx;
   logic [23:0]     shift;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]      csum;
`endif

   logic            accept;
   logic [ADDR_W:0] next_cnt;
   logic            last_word;

   // A byte only counts when both sides agree in the same cycle; bytes
   // offered while byte_rdy is low are simply dropped.
   assign accept    = byte_vld && byte_rdy;
   assign next_cnt  = word_cnt + (ADDR_W+1)'(1);
   assign last_word = (int'(next_cnt) == int'(len));

   // Frame sequencer. All outputs are registered here; byte_rdy and busy
   // are updated together with every state change so that they always
   // describe the state being entered. The first three bytes of a word
   // are parked in 'shift' and the fourth completes the word directly
   // into wdata, so the next word can start assembling while we pulses.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_IDLE;
         len      <= '0;
         byte_idx <= '0;
         shift    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
         byte_rdy <= 1'b0;
         we       <= 1'b0;
         waddr    <= BASE;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         word_cnt <= '0;
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN;
                  byte_rdy <= 1'b1;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  word_cnt <= '0;
                  byte_idx <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end

            S_LEN: begin
               if (accept) begin
                  if (byte_in == 8'd0 || int'(byte_in) > MAX_WORDS) begin
                     state    <= S_ERR;
                     err      <= 1'b1;
                     byte_rdy <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     len   <= byte_in;
                     state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (accept) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  csum <= csum ^ byte_in;
`endif
                  if (byte_idx == 2'd3) begin
                     // Address wraps naturally in the ADDR_W-bit sum.
                     wdata    <= {shift, byte_in};
                     waddr    <= BASE + word_cnt[ADDR_W-1:0];
                     we       <= 1'b1;
                     word_cnt <= next_cnt;
                     byte_idx <= 2'd0;
                     if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state    <= S_CSUM;
`else
                        state    <= S_FIN;
                        byte_rdy <= 1'b0;
`endif
                     end
                  end else begin
                     shift    <= {shift[15:0], byte_in};
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end

`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (accept) begin
                  byte_rdy <= 1'b0;
                  if (byte_in == csum) begin
                     state <= S_FIN;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
`endif

            S_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state    <= S_IDLE;
               byte_rdy <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader
//
// Self-checking bench for inst_loader. Frames are built as byte queues,
// driven with optional random idle gaps, and every RAM write and done
// pulse is collected by a monitor. A frame-level reference model derives
// the expected writes, done, err and word_cnt straight from the frame
// contents. Honours INST_LOADER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_inst_loader;

   localparam int ADDR_W    = 6;
   localparam int BASE_ADDR = 0;

   logic              clk = 1'b0;
   logic              clr = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_vld = 1'b0;
   logic              byte_rdy;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [32:1]       wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_cnt;

   inst_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .byte_in  (byte_in),
      .byte_vld (byte_vld),
      .byte_rdy (byte_rdy),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0]         frame[$];
   logic [ADDR_W+31:0] obs_q[$];
   logic [ADDR_W+31:0] exp_q[$];
   int                 done_cnt = 0;
   int                 exp_done;
   int                 exp_err;
   int                 exp_cnt;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expv);
      end
   endtask

   // Collect writes and done pulses on the falling edge, away from updates.
   always @(negedge clk) begin
      if (we === 1'b1) obs_q.push_back({waddr, wdata});
      if (done === 1'b1) done_cnt++;
   end

   // Abort a stuck run instead of hanging.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: expected writes and status from the frame alone.
   // 'cut' is the number of frame bytes delivered before a clr (-1: none).
   task automatic model(input int cut);
      int n, delivered, nw;
      logic [7:0] x;
      exp_q.delete();
      n = int'(frame[0]);
      delivered = (cut < 0) ? frame.size() : cut;
      if (n == 0 || n > (1 << ADDR_W)) begin
         exp_err = 1; exp_done = 0; exp_cnt = 0;
         return;
      end
      nw = (delivered - 1) / 4;
      if (nw > n) nw = n;
      for (int i = 0; i < nw; i++)
         exp_q.push_back({ADDR_W'((BASE_ADDR + i) % (1 << ADDR_W)),
                          frame[1+4*i], frame[2+4*i], frame[3+4*i], frame[4+4*i]});
      if (cut >= 0) begin
         exp_err = 0; exp_done = 0; exp_cnt = 0;
      end else begin
         exp_cnt = n;
`ifdef INST_LOADER_CHECKSUM_EN
         x = 8'h00;
         for (int j = 1; j <= 4*n; j++) x = x ^ frame[j];
         exp_done = (frame[4*n+1] == x) ? 1 : 0;
         exp_err  = 1 - exp_done;
`else
         x = 8'h00;
         exp_done = 1; exp_err = 0;
`endif
      end
   endtask

   task automatic add_csum(input bit corrupt);
`ifdef INST_LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      for (int j = 1; j < frame.size(); j++) x = x ^ frame[j];
      frame.push_back(corrupt ? (x ^ 8'h01) : x);
`else
      if (corrupt) frame.push_back(8'h00);
`endif
   endtask

   task automatic build_frame(input int n, input bit corrupt);
      frame.delete();
      frame.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) frame.push_back(8'($urandom));
      add_csum(corrupt);
   endtask

   // Offer one byte after a random idle gap; give up after 8 refused cycles.
   task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
      int tries;
      tries = 0;
      ok = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
         @(negedge clk);
         byte_vld = 1'b0;
         byte_in  = 8'($urandom);
      end
      while (tries < 8 && !ok) begin
         @(negedge clk);
         byte_in  = b;
         byte_vld = 1'b1;
         if (byte_rdy === 1'b1) begin
            ok = 1'b1;
            @(posedge clk);
         end else begin
            tries++;
         end
      end
   endtask

   // Drive one frame: junk bytes while idle, start pulse, frame bytes,
   // optionally a clr after 'cut' accepted bytes.
   task automatic applyStimulus(input int gap_max, input int cut);
      bit ok;
      int sent;
      repeat (3) begin
         @(negedge clk);
         byte_vld = 1'b1;
         byte_in  = 8'($urandom);
      end
      obs_q.delete();
      done_cnt = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; byte_vld = 1'b0;
      sent = 0;
      foreach (frame[i]) begin
         if (cut >= 0 && sent == cut) break;
         send_byte(frame[i], gap_max, ok);
         if (!ok) break;
         sent++;
      end
      @(negedge clk);
      byte_vld = 1'b0;
      if (cut >= 0 && sent == cut) begin
         clr = 1'b1;
         @(negedge clk);
         checkOutput("clr.byte_rdy", byte_rdy, 0);
         checkOutput("clr.we",       we, 0);
         checkOutput("clr.waddr",    waddr, BASE_ADDR);
         checkOutput("clr.wdata",    wdata, 0);
         checkOutput("clr.busy",     busy, 0);
         checkOutput("clr.err",      err, 0);
         checkOutput("clr.word_cnt", word_cnt, 0);
         clr = 1'b0;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_frame(input string tag);
      int m;
      checkOutput({tag, ".nwrites"}, obs_q.size(), exp_q.size());
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         checkOutput($sformatf("%s.write%0d", tag, i), obs_q[i], exp_q[i]);
      checkOutput({tag, ".done"},     done_cnt, exp_done);
      checkOutput({tag, ".err"},      err, exp_err);
      checkOutput({tag, ".word_cnt"}, word_cnt, exp_cnt);
      checkOutput({tag, ".busy"},     busy, 0);
      checkOutput({tag, ".byte_rdy"}, byte_rdy, 0);
   endtask

   task automatic run_frame(input string tag, input int gap_max, input int cut);
      model(cut);
      applyStimulus(gap_max, cut);
      check_frame(tag);
   endtask

   task automatic basic_frame();
      frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      add_csum(1'b0);
   endtask

   initial begin
      // Reset with start held: clr must win.
      clr = 1'b1; start = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst.byte_rdy", byte_rdy, 0);
      checkOutput("rst.we",       we, 0);
      checkOutput("rst.waddr",    waddr, BASE_ADDR);
      checkOutput("rst.wdata",    wdata, 0);
      checkOutput("rst.busy",     busy, 0);
      checkOutput("rst.done",     done, 0);
      checkOutput("rst.err",      err, 0);
      checkOutput("rst.word_cnt", word_cnt, 0);
      clr = 1'b0; start = 1'b0;
      @(negedge clk);

      // Basic load, back-to-back, with explicit known words.
      basic_frame();
      run_frame("basic", 0, -1);
      if (obs_q.size() == 2) begin
         checkOutput("basic.w0", obs_q[0], {6'd0, 32'h12345678});
         checkOutput("basic.w1", obs_q[1], {6'd1, 32'h9ABCDEF0});
      end else begin
         checkOutput("basic.count", obs_q.size(), 2);
      end

      // Same frame with idle gaps between bytes.
      basic_frame();
      run_frame("gapped", 3, -1);

      // Length errors, then recovery from the error state.
      frame = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame("len0", 0, -1);
      frame = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame("len65", 0, -1);
      basic_frame();
      run_frame("recover", 1, -1);

      // clr after 6 of 8 data bytes (7 frame bytes including length).
      basic_frame();
      run_frame("cut", 1, 7);

`ifdef INST_LOADER_CHECKSUM_EN
      frame = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      run_frame("csum_ok", 0, -1);
      frame = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      run_frame("csum_bad", 0, -1);
`endif

      // Full RAM boundary.
      build_frame(1 << ADDR_W, 1'b0);
      run_frame("full", 0, -1);

      // Randomized frames.
      for (int k = 0; k < 12; k++) begin
         build_frame($urandom_range(1, 8), ($urandom_range(0, 3) == 0));
         run_frame($sformatf("rand%0d", k), $urandom_range(0, 3), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
